// File: rtl/hex_keypad_scanner_if.sv
// Key-code delivery channel: head-of-FIFO code with valid/ready, plus status flags.
// The master side (scanner) drives the code and status; the slave side consumes.
interface hex_keypad_scanner_if;
  logic [3:0] keyCode;
  logic       keyValid;
  logic       keyReady;
  logic       keyHeld;
  logic       keyDrop;

  modport master (
    output keyCode,
    output keyValid,
    output keyHeld,
    output keyDrop,
    input  keyReady
  );

  modport slave (
    input  keyCode,
    input  keyValid,
    input  keyHeld,
    input  keyDrop,
    output keyReady
  );
endinterface

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, frame debounce, single-key FSM, and a
// small code FIFO that hands one code per accepted press to the consumer.
module hex_keypad_scanner #(
  parameter int SCAN_DIV       = 12000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic [3:0]                   keyRow,
  output logic [3:0]                   keyCol,
  hex_keypad_scanner_if.master         keyIf
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] DEB_PRE  = CNT_W'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_BLOCKED
  } state_t;

  logic [3:0]        rowMeta_q;
  logic [3:0]        rowSync_q;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        col_q, col_d;
  logic              tick;

  logic [15:0]       frame_q, frame_d;
  logic [15:0]       prevFrame_q, prevFrame_d;
  logic [CNT_W-1:0]  stable_q, stable_d;
  logic              frameDone;
  logic              frameChanged;
  logic              qualify;

  logic              noKeys;
  logic              oneKey;
  logic [3:0]        keyIdx;
  logic [3:0]        keyCodeNew;

  state_t            state_q, state_d;
  logic [3:0]        heldCode_q, heldCode_d;
  logic              push;

  logic [3:0]        mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic              fifoFull;
  logic              fifoValid;
  logic              pop;
  logic              doPush;
  logic              drop_q, drop_d;

  // Row synchronizer: idles at all-ones so reset looks like "no key".
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rowMeta_q <= 4'hF;
      rowSync_q <= 4'hF;
    end else begin
      rowMeta_q <= keyRow;
      rowSync_q <= rowMeta_q;
    end
  end

  assign tick   = (div_q == DIV_LAST);
  assign keyCol = ~(4'b0001 << col_q);

  always_comb begin
    div_d = div_q + 1'b1;
    col_d = col_q;
    if (tick) begin
      div_d = '0;
      col_d = col_q + 2'd1;
    end
  end

  // frame_d already includes this tick's capture so the frame-complete
  // comparison sees all four columns of the frame.
  always_comb begin
    frame_d = frame_q;
    if (tick) begin
      frame_d[{col_q, 2'b00} +: 4] = ~rowSync_q;
    end
  end

  assign frameDone    = tick && (col_q == 2'd3);
  assign frameChanged = (frame_d != prevFrame_q);

  always_comb begin
    prevFrame_d = prevFrame_q;
    stable_d    = stable_q;
    qualify     = 1'b0;
    if (frameDone) begin
      if (frameChanged) begin
        prevFrame_d = frame_d;
        stable_d    = CNT_W'(1);
        qualify     = (DEBOUNCE_SCANS == 1);
      end else if (stable_q != DEB_MAX) begin
        stable_d = stable_q + 1'b1;
        qualify  = (stable_q == DEB_PRE);
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      div_q       <= '0;
      col_q       <= 2'd0;
      frame_q     <= '0;
      prevFrame_q <= '0;
      stable_q    <= '0;
    end else begin
      div_q       <= div_d;
      col_q       <= col_d;
      frame_q     <= frame_d;
      prevFrame_q <= prevFrame_d;
      stable_q    <= stable_d;
    end
  end

  // Classify the qualifying frame; frame bit index is col*4+row, code is row*4+col.
  assign noKeys = (frame_d == 16'h0000);
  assign oneKey = !noKeys && ((frame_d & (frame_d - 16'h0001)) == 16'h0000);

  always_comb begin
    keyIdx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_d[i]) keyIdx = 4'(i);
    end
  end

  assign keyCodeNew = {keyIdx[1:0], keyIdx[3:2]};

  always_comb begin
    state_d    = state_q;
    heldCode_d = heldCode_q;
    push       = 1'b0;
    if (qualify) begin
      unique case (state_q)
        S_IDLE: begin
          if (oneKey) begin
            push       = 1'b1;
            heldCode_d = keyCodeNew;
            state_d    = S_PRESSED;
          end else if (!noKeys) begin
            state_d = S_BLOCKED;
          end
        end
        S_PRESSED: begin
          if (noKeys) begin
            state_d = S_IDLE;
          end else if (!(oneKey && (keyCodeNew == heldCode_q))) begin
            state_d = S_BLOCKED;
          end
        end
        S_BLOCKED: begin
          if (noKeys) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= S_IDLE;
      heldCode_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      heldCode_q <= heldCode_d;
    end
  end

  // FIFO: extra pointer bit separates full from empty; a pop frees the slot
  // a same-cycle push needs, so push+pop while full both succeed.
  assign fifoValid = (wr_q != rd_q);
  assign fifoFull  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop       = fifoValid && keyIf.keyReady;
  assign doPush    = push && (!fifoFull || pop);

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    drop_d = push && fifoFull && !pop;
    if (doPush) wr_d = wr_q + 1'b1;
    if (pop)    rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_q   <= '0;
      rd_q   <= '0;
      drop_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wr_q[AW-1:0]] <= heldCode_d;
  end

  assign keyIf.keyValid = fifoValid;
  assign keyIf.keyCode  = fifoValid ? mem_q[rd_q[AW-1:0]] : 4'd0;
  assign keyIf.keyHeld  = (state_q == S_PRESSED);
  assign keyIf.keyDrop  = drop_q;

endmodule
